// File: rtl/fft16_unloader.sv
// Parallel-to-serial output stage of the 16-point FFT: ping-pong frame buffers
// drained one complex bin per beat over a valid/ready stream.
module fft16_unloader #(
   parameter int W         = 17,
   parameter int OUT_ORDER = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                frame_valid,
   output logic                frame_ready,
   input  logic [16*W-1:0]     frame_re,
   input  logic [16*W-1:0]     frame_im,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_re,
   output logic signed [W-1:0] out_im,
   output logic [3:0]          out_idx,
   output logic                out_last
);

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   logic [16*W-1:0] r_buf_re [2];
   logic [16*W-1:0] r_buf_im [2];
   logic [1:0]      r_full;
   logic            r_wr_sel;
   logic            r_rd_sel;
   logic [3:0]      r_cnt;

   logic            w_cap;
   logic            w_pop;
   logic [3:0]      w_m;

   assign frame_ready = !r_full[r_wr_sel];
   assign w_cap       = frame_valid && frame_ready && !flush;
   assign w_pop       = out_valid && out_ready && !flush;

   // Buffer contents carry no reset; occupancy is tracked by r_full alone.
   always_ff @(posedge clk) begin
      if (w_cap) begin
         r_buf_re[r_wr_sel] <= frame_re;
         r_buf_im[r_wr_sel] <= frame_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_cnt    <= 4'd0;
      end else if (flush) begin
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_cnt    <= 4'd0;
      end else begin
         // Capture and pop never address the same buffer: one needs it empty, the other full.
         if (w_cap) begin
            r_full[r_wr_sel] <= 1'b1;
            r_wr_sel         <= ~r_wr_sel;
         end
         if (w_pop) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
               r_full[r_rd_sel] <= 1'b0;
               r_rd_sel         <= ~r_rd_sel;
            end
         end
      end
   end

   always_comb begin
      w_m       = (OUT_ORDER != 0) ? bitrev4(r_cnt) : r_cnt;
      out_valid = r_full[r_rd_sel];
      out_re    = '0;
      out_im    = '0;
      out_idx   = 4'd0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_re   = r_buf_re[r_rd_sel][w_m*W +: W];
         out_im   = r_buf_im[r_rd_sel][w_m*W +: W];
         out_idx  = w_m;
         out_last = (r_cnt == 4'd15);
      end
   end

endmodule

// File: tb/tb_fft16_unloader.sv
// Directed bench for fft16_unloader: natural and bit-reversed instances share stimulus.
module tb_fft16_unloader;
   localparam int W = 17;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            frame_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [16*W-1:0] frame_re = '0;
   logic [16*W-1:0] frame_im = '0;

   logic                frame_ready0, out_valid0, out_last0;
   logic signed [W-1:0] out_re0, out_im0;
   logic [3:0]          out_idx0;
   logic                frame_ready1, out_valid1, out_last1;
   logic signed [W-1:0] out_re1, out_im1;
   logic [3:0]          out_idx1;

   int n_chk = 0;
   int n_fail = 0;
   int rev_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   always #5 clk = ~clk;

   fft16_unloader #(.W(W), .OUT_ORDER(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .frame_valid(frame_valid), .frame_ready(frame_ready0),
      .frame_re(frame_re), .frame_im(frame_im),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_re(out_re0), .out_im(out_im0), .out_idx(out_idx0), .out_last(out_last0)
   );

   fft16_unloader #(.W(W), .OUT_ORDER(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .frame_valid(frame_valid), .frame_ready(frame_ready1),
      .frame_re(frame_re), .frame_im(frame_im),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_re(out_re1), .out_im(out_im1), .out_idx(out_idx1), .out_last(out_last1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input int base);
      for (int k = 0; k < 16; k++) begin
         frame_re[k*W +: W] = W'(base + k);
         frame_im[k*W +: W] = W'(-(base + k));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Captures one frame and checks all 16 beats on both instances with out_ready high.
   task automatic run_frame(input int base);
      out_ready = 1'b1;
      load_frame(base);
      frame_valid = 1'b1;
      chk("accept_ready", 32'(frame_ready0), 32'd1);
      step();
      frame_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         chk("nat_valid", 32'(out_valid0), 32'd1);
         chk("nat_re", out_re0, base + b);
         chk("nat_im", out_im0, -(base + b));
         chk("nat_idx", 32'(out_idx0), b);
         chk("nat_last", 32'(out_last0), (b == 15) ? 1 : 0);
         chk("rev_idx", 32'(out_idx1), rev_tbl[b]);
         chk("rev_re", out_re1, base + rev_tbl[b]);
         chk("rev_last", 32'(out_last1), (b == 15) ? 1 : 0);
         step();
      end
      chk("nat_idle_valid", 32'(out_valid0), 32'd0);
      chk("rev_idle_valid", 32'(out_valid1), 32'd0);
      chk("idle_re_zero", out_re0, 0);
   endtask

   initial begin
      int beats;
      int fi;
      int acc_edge [3];
      int bases [3];
      logic acc_now;
      logic pop_now;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid0), 32'd0);
      chk("rst_ready", 32'(frame_ready0), 32'd1);
      chk("rst_re", out_re0, 0);
      chk("rst_idx", 32'(out_idx0), 0);
      chk("rst_last", 32'(out_last0), 0);
      rst_n = 1'b1;
      step();

      // Single frame, both orders
      run_frame(0);

      // Three back-to-back frames
      bases = '{32'h100, 32'h200, 32'h300};
      acc_edge = '{-1, -1, -1};
      fi = 0;
      beats = 0;
      out_ready = 1'b1;
      load_frame(bases[0]);
      frame_valid = 1'b1;
      for (int cyc = 0; cyc < 80 && beats < 48; cyc++) begin
         if (beats > 0) chk("b2b_no_gap", 32'(out_valid0), 32'd1);
         if (out_valid0) begin
            chk("b2b_re", out_re0, bases[beats/16] + (beats % 16));
            chk("b2b_idx", 32'(out_idx0), beats % 16);
            chk("b2b_last", 32'(out_last0), ((beats % 16) == 15) ? 1 : 0);
            beats++;
         end
         acc_now = frame_valid && frame_ready0;
         step();
         if (acc_now) begin
            acc_edge[fi] = cyc;
            fi++;
            if (fi == 3) frame_valid = 1'b0;
            else load_frame(bases[fi]);
         end
      end
      frame_valid = 1'b0;
      chk("b2b_beats", beats, 48);
      chk("b2b_acc1", acc_edge[0], 0);
      chk("b2b_acc2", acc_edge[1], 1);
      chk("b2b_acc3", acc_edge[2], 17);
      chk("b2b_done_valid", 32'(out_valid0), 0);

      // Stalls with out_ready pattern 1,0,0
      load_frame(32'h40);
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      beats = 0;
      for (int cyc = 0; cyc < 80 && beats < 16; cyc++) begin
         chk("stall_valid", 32'(out_valid0), 1);
         chk("stall_re", out_re0, 32'h40 + beats);
         chk("stall_idx", 32'(out_idx0), beats);
         chk("stall_last", 32'(out_last0), (beats == 15) ? 1 : 0);
         out_ready = ((cyc % 3) == 0);
         pop_now = out_valid0 && out_ready;
         step();
         if (pop_now) beats++;
      end
      out_ready = 1'b1;
      chk("stall_beats", beats, 16);
      chk("stall_done_valid", 32'(out_valid0), 0);

      // Flush on beat 5 of A while B is buffered, with C offered in the flush cycle
      load_frame(32'h500);
      frame_valid = 1'b1;
      step();
      load_frame(32'h600);
      step();
      frame_valid = 1'b0;
      repeat (4) step();
      chk("pre_flush_re", out_re0, 32'h505);
      chk("pre_flush_ready", 32'(frame_ready0), 0);
      flush = 1'b1;
      load_frame(32'h700);
      frame_valid = 1'b1;
      step();
      flush = 1'b0;
      frame_valid = 1'b0;
      chk("flush_valid", 32'(out_valid0), 0);
      chk("flush_ready", 32'(frame_ready0), 1);
      step();
      chk("flush_still_empty", 32'(out_valid0), 0);
      run_frame(32'h700);

      // Asynchronous reset mid-frame
      load_frame(32'h800);
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      repeat (6) step();
      chk("pre_rst_re", out_re0, 32'h806);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid0), 0);
      chk("arst_re", out_re0, 0);
      chk("arst_im", out_im0, 0);
      chk("arst_idx", 32'(out_idx1), 0);
      chk("arst_ready", 32'(frame_ready0), 1);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(out_valid0), 0);
      run_frame(32'h900);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
